// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Port 0 (execute stage) has fixed priority. Port 1 (auxiliary engine) is
// force-granted after MAX_WAIT consecutive lost cycles. Each port owns a
// one-deep response slot that is loaded on the edge after an accept.
// Optional build macro: ALU_ARB_STATS_EN adds saturating grant statistics.
module alu_arbiter #(
  parameter int OP_W     = 16,
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [31:0]     req0_rd_i,
  input  logic [31:0]     req0_rs_i,
  input  logic [OP_W-1:0] req0_op_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [31:0]     req1_rd_i,
  input  logic [31:0]     req1_rs_i,
  input  logic [OP_W-1:0] req1_op_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic [31:0]     rsp0_result_o,
  output logic            rsp0_jump_o,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [31:0]     rsp1_result_o,
  output logic            rsp1_jump_o,
  output logic [31:0]     alu_rd_o,
  output logic [31:0]     alu_rs_o,
  output logic [OP_W-1:0] alu_op_o,
  input  logic [31:0]     alu_result_i,
  input  logic            alu_jump_i
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0_o,
  output logic [STAT_W-1:0] stat_grant1_o,
  output logic [STAT_W-1:0] stat_forced_o
`endif
);

  // Reject configurations the 4-bit starvation counter cannot represent.
  generate
    if (MAX_WAIT < 1 || MAX_WAIT > 15 || STAT_W < 1) begin : g_bad_param
      $error("alu_arbiter: MAX_WAIT must be 1..15 and STAT_W >= 1");
    end
  endgenerate

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  // The ALU leaves unused outputs undefined; keep stored slots clean in
  // simulation while synthesis captures the value unchanged.
`ifdef SYNTHESIS
  function automatic logic [31:0] x_to_zero32(input logic [31:0] v);
    return v;
  endfunction
  function automatic logic x_to_zero1(input logic v);
    return v;
  endfunction
`else
  function automatic logic [31:0] x_to_zero32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (v[i] === 1'b1);
    return r;
  endfunction
  function automatic logic x_to_zero1(input logic v);
    return (v === 1'b1);
  endfunction
`endif

  logic        elig0, elig1;
  logic        grant0, grant1;
  logic        starved;
  logic [3:0]  starv_cnt_p0;
  logic [31:0] alu_result_clean;
  logic        alu_jump_clean;

  logic        rsp0_vld_p1, rsp1_vld_p1;
  logic [31:0] rsp0_result_p1, rsp1_result_p1;
  logic        rsp0_jump_p1, rsp1_jump_p1;

  // ---- stage p0: eligibility, grant and ALU operand drive ----
  assign elig0   = req0_valid_i & (~rsp0_vld_p1 | rsp0_ready_i);
  assign elig1   = req1_valid_i & (~rsp1_vld_p1 | rsp1_ready_i);
  assign starved = (starv_cnt_p0 == WAIT_MAX);

  // Priority grant: starved port 1, then port 0, then port 1; none in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig1 && starved)  grant1 = 1'b1;
      else if (elig0)        grant0 = 1'b1;
      else if (elig1)        grant1 = 1'b1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Forward the granted port's operands to the ALU, zero when idle.
  always_comb begin
    alu_rd_o = '0;
    alu_rs_o = '0;
    alu_op_o = '0;
    if (grant0) begin
      alu_rd_o = req0_rd_i;
      alu_rs_o = req0_rs_i;
      alu_op_o = req0_op_i;
    end else if (grant1) begin
      alu_rd_o = req1_rd_i;
      alu_rs_o = req1_rs_i;
      alu_op_o = req1_op_i;
    end
  end

  assign alu_result_clean = x_to_zero32(alu_result_i);
  assign alu_jump_clean   = x_to_zero1(alu_jump_i);

  // Count consecutive cycles port 1 is eligible but loses, saturating.
  always_ff @(posedge clk) begin
    if (reset)                   starv_cnt_p0 <= 4'd0;
    else if (grant1 || !elig1)   starv_cnt_p0 <= 4'd0;
    else if (!starved)           starv_cnt_p0 <= starv_cnt_p0 + 4'd1;
  end

  // ---- stage p1: per-port response slots ----
  // Port 0 slot: load on accept (overrides drain), clear on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_vld_p1    <= 1'b0;
      rsp0_result_p1 <= '0;
      rsp0_jump_p1   <= 1'b0;
    end else if (grant0) begin
      rsp0_vld_p1    <= 1'b1;
      rsp0_result_p1 <= alu_result_clean;
      rsp0_jump_p1   <= alu_jump_clean;
    end else if (rsp0_vld_p1 && rsp0_ready_i) begin
      rsp0_vld_p1    <= 1'b0;
    end
  end

  // Port 1 slot: same policy as port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp1_vld_p1    <= 1'b0;
      rsp1_result_p1 <= '0;
      rsp1_jump_p1   <= 1'b0;
    end else if (grant1) begin
      rsp1_vld_p1    <= 1'b1;
      rsp1_result_p1 <= alu_result_clean;
      rsp1_jump_p1   <= alu_jump_clean;
    end else if (rsp1_vld_p1 && rsp1_ready_i) begin
      rsp1_vld_p1    <= 1'b0;
    end
  end

  assign rsp0_valid_o  = rsp0_vld_p1;
  assign rsp0_result_o = rsp0_result_p1;
  assign rsp0_jump_o   = rsp0_jump_p1;
  assign rsp1_valid_o  = rsp1_vld_p1;
  assign rsp1_result_o = rsp1_result_p1;
  assign rsp1_jump_o   = rsp1_jump_p1;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_g0, stat_g1, stat_f;

  // Saturating grant statistics, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_g0 <= '0;
      stat_g1 <= '0;
      stat_f  <= '0;
    end else begin
      if (grant0 && stat_g0 != '1)            stat_g0 <= stat_g0 + 1'b1;
      if (grant1 && stat_g1 != '1)            stat_g1 <= stat_g1 + 1'b1;
      if (grant1 && starved && stat_f != '1)  stat_f  <= stat_f + 1'b1;
    end
  end

  assign stat_grant0_o = stat_g0;
  assign stat_grant1_o = stat_g1;
  assign stat_forced_o = stat_f;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single core ALU between two requesters: port 0 (core execute stage) and port 1 (auxiliary engine, e.g. a crypto/rotate accelerator).
- Each port issues ALU operations through a valid/ready handshake and receives a registered result/jump response one cycle later.
- Port 0 has fixed priority; an anti-starvation counter forces a port 1 grant after MAX_WAIT consecutive losses.
- Sits between the requesters and the combinational ALU. It drives the ALU operand/opcode inputs and captures the ALU outputs.

Parameters:
- OP_W, 16, width of the opaque instruction/opcode word forwarded to the ALU unmodified.
- MAX_WAIT, 4, number of consecutive cycles port 1 may be valid and lose arbitration before it is force-granted (range 1..15).
- STAT_W, 16, width of the grant statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid_i / req1_valid_i  in  1  port requests an ALU operation.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
- req0_rd_i / req1_rd_i  in  32  rd operand.
- req0_rs_i / req1_rs_i  in  32  rs operand.
- req0_op_i / req1_op_i  in  OP_W  instruction word.
- rsp0_valid_o / rsp1_valid_o  out  1  response held in port slot.
- rsp0_ready_i / rsp1_ready_i  in  1  requester consumes response.
- rsp0_result_o / rsp1_result_o  out  32  captured ALU result.
- rsp0_jump_o / rsp1_jump_o  out  1  captured ALU jump decision.
- alu_rd_o, alu_rs_o  out  32  ALU operands.
- alu_op_o  out  OP_W  ALU instruction.
- alu_result_i  in  32  ALU result (combinational from alu_*_o).
- alu_jump_i  in  1  ALU jump_now.

Behaviour:
- Reset: all rsp*_valid_o=0, rsp*_result_o=0, rsp*_jump_o=0, starvation counter=0. The ALU drive outputs are 0 while no grant is active, including during reset.
- Port n is eligible when reqn_valid_i=1 and (rspn_valid_o=0 or rspn_ready_i=1). The response slot must be free or draining in the same cycle.
- Grant (combinational, one per cycle):
  - Port 1 if it is eligible and the starvation count equals MAX_WAIT.
  - Otherwise port 0 if eligible.
  - Otherwise port 1 if eligible.
  - Otherwise none.
- reqn_ready_o = grant to n. Ready never depends on that port's own valid via a loop beyond eligibility.
- With a grant, alu_rd_o/alu_rs_o/alu_op_o = granted port's operands, same cycle. With no grant they are 0.
- Edge after an accepted request (valid&ready): the slot loads alu_result_i and alu_jump_i, and rspn_valid_o=1. Latency is exactly 1 cycle.
- Captured X from the ALU (branch ops leave result X; ALU ops leave jump X) is stored as 0. Implement this as a per-bit X-to-0 cleanup in simulation only; synthesis stores the value as-is.
- Slot clears when rspn_valid_o&rspn_ready_i and no new accept for n that cycle. Accept plus drain in the same cycle overwrites the slot, and valid stays 1.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) each cycle port 1 is eligible but not granted.
  - Resets to 0 on a port 1 grant or when port 1 is not eligible.
- Throughput: one accept per cycle total. Back-to-back accepts on the same port are allowed when the consumer drains each cycle.
- Reset asserted mid-stream discards held responses. Requests presented in the reset cycle are not accepted (ready=0).

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds outputs stat_grant0_o and stat_grant1_o (STAT_W each), and stat_forced_o (STAT_W) counting starvation-forced grants.
  - All three are saturating and cleared by reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single port 0 ADDU rd=5 rs=7, rsp0_ready=1 -> ready0 same cycle, alu_rd_o=5, rsp0_valid=1 and rsp0_result=12 next cycle, then valid=0.
- Both valid every cycle with both consumers ready, MAX_WAIT=4 -> grants 0,0,0,0,1,0,0,0,0,1 repeating; a port 1 response arrives every 5th cycle.
- Port 0 response held (rsp0_ready=0) with req0 still valid -> ready0=0, port 1 granted every cycle. rsp0_result stays stable until drained.
- Same-cycle drain+accept on port 1 (results 3 then 9) -> rsp1_valid stays 1, result goes 3→9 with no bubble.
- Reset asserted while rsp0_valid=1 and req1 valid -> next cycle all rsp valid=0, counter=0, no ready during reset.
- With ALU_ARB_STATS_EN: 10 contended cycles, MAX_WAIT=4 -> stat_grant0=8, stat_grant1=2, stat_forced=2.
